pipe_stage_skid: RTL
====================

# pipe_stage_skid

Parametrised elastic pipeline stage register for the pipelined RISC-V core, replacing fixed, always-load stage registers such as the MEM/WB register. It carries a generic payload (control bits, N data words, destination register) across one stage boundary using a valid/ready handshake. A two-entry skid buffer gives full throughput under downstream back-pressure. It also provides synchronous flush (bubble insertion), guaranteed-zero control outputs on bubbles, and a saturating bubble counter for performance measurement.

## Interface
- DATA_WIDTH, 32, width of each data word (ALU result, read data, PC target, PC+4, ...)
- NUM_DATA, 5, number of DATA_WIDTH words in the payload
- CTRL_WIDTH, 4, control-bit count (RegWrite, ResultSrc, jump selects, ...)
- RD_WIDTH, 5, destination register index width
- CNT_WIDTH, 16, bubble counter width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- valid_i  in  1  upstream payload valid
- ready_o  out  1  stage can accept this cycle
- ctrl_i  in  CTRL_WIDTH  control bits
- data_i  in  NUM_DATA*DATA_WIDTH  data words, word k at bits [k*DATA_WIDTH +: DATA_WIDTH]
- rd_i  in  RD_WIDTH  destination register
- flush_i  in  1  discard all held and incoming entries
- valid_o  out  1  output payload valid
- ready_i  in  1  downstream accepts this cycle
- ctrl_o, data_o, rd_o  out  as inputs  registered payload
- bubble_cnt_o  out  CNT_WIDTH  saturating count of cycles with valid_o=0

## Operation
- accept = valid_i & ready_o; emit = valid_o & ready_i.
- Storage: main register (drives outputs) and skid register; state EMPTY / ONE / FULL.
- EMPTY: accept -> ONE, main<=input.
- ONE: accept & emit -> ONE, main<=input. accept & !emit -> FULL, skid<=input. !accept & emit -> EMPTY. Otherwise hold.
- FULL: emit -> ONE, main<=skid. Otherwise hold. No accept, since ready_o=0.
- ready_o = !rst & (state != FULL). Depends on state and rst only; no combinational path from ready_i or valid_i.
- valid_o = (state != EMPTY).
- ctrl_o, data_o, rd_o are forced to all-zero whenever valid_o=0, so a bubble never asserts RegWrite or a jump select.
- Order is strictly FIFO; no entry is duplicated or dropped except by flush/reset.
- Priority: rst > flush_i > handshake.
  - flush_i=1: next state EMPTY, both registers cleared, the same-cycle input is discarded even if accept=1, and the same-cycle emit still counts downstream.
- bubble_cnt_o increments by 1 on each non-reset cycle where valid_o=0, saturates at 2^CNT_WIDTH-1, and is unaffected by flush.

## Timing
- Reset: state EMPTY; valid_o=0; ctrl_o/data_o/rd_o=0; bubble_cnt_o=0; ready_o=0 while rst=1, and 1 on the first cycle after rst falls.
- Latency: input accepted at edge N appears on outputs in cycle N+1 (one register stage).
- Throughput: one transfer per cycle while ready_i=1.
- Back-pressure: the first stall cycle is absorbed by skid; ready_o drops the cycle after entering FULL.
- After the stall clears, the skid entry emits at most 2 cycles later; ready_o returns 1 the cycle after leaving FULL.
- Flush takes effect at the next edge: valid_o=0 and ready_o=1 in the following cycle.
- Reset mid-operation behaves identically to flush, and additionally clears the counter.

## Test plan
- Streaming: ready_i=1, valid_i=1, rd_i=1,2,3,... -> rd_o=1,2,3,... one cycle later; valid_o continuous; ready_o stays 1; bubble_cnt_o constant after the first valid cycle.
- Back-pressure: stream A,B,C with ready_i=0 from cycle 2 -> A held on outputs, B in skid, ready_o=0. Then ready_i=1 -> A, B, C emitted in order, none lost.
- Bubble zeroing: valid_i=0 after a payload with ctrl_i=4'b1111 -> next cycle valid_o=0, ctrl_o=0, rd_o=0, data_o=0.
- Flush in FULL with valid_i=1 -> next cycle valid_o=0, ready_o=1, and the flushed/incoming entries never appear on outputs.
- Reset mid-stream with the counter at 7 -> valid_o=0, bubble_cnt_o=0, ready_o=0 during rst, 1 after.
- Counter saturation with CNT_WIDTH=4, idle 20 cycles -> bubble_cnt_o sticks at 15.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// Elastic valid/ready pipeline stage with a two-entry skid buffer, synchronous flush,
// bubble-zeroed payload outputs and a saturating bubble counter.
//
// state   | meaning
// S_EMPTY | nothing held, outputs are a bubble
// S_ONE   | main register holds the head entry
// S_FULL  | main holds the head, skid holds the next entry, ready_o low
module pipe_stage_skid #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_DATA   = 5,
    parameter int CTRL_WIDTH = 4,
    parameter int RD_WIDTH   = 5,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           valid_i,
    output logic                           ready_o,
    input  logic [CTRL_WIDTH-1:0]          ctrl_i,
    input  logic [NUM_DATA*DATA_WIDTH-1:0] data_i,
    input  logic [RD_WIDTH-1:0]            rd_i,
    input  logic                           flush_i,
    output logic                           valid_o,
    input  logic                           ready_i,
    output logic [CTRL_WIDTH-1:0]          ctrl_o,
    output logic [NUM_DATA*DATA_WIDTH-1:0] data_o,
    output logic [RD_WIDTH-1:0]            rd_o,
    output logic [CNT_WIDTH-1:0]           bubble_cnt_o
);

    localparam int PW = CTRL_WIDTH + NUM_DATA*DATA_WIDTH + RD_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [PW-1:0]     r_main;
    logic [PW-1:0]     r_skid;
    logic [CNT_WIDTH-1:0] r_bubble_cnt;
    logic [PW-1:0]     w_in;
    logic [PW-1:0]     w_out;
    logic              w_accept;
    logic              w_emit;
    logic              w_load_main_in;
    logic              w_load_main_skid;
    logic              w_load_skid;

    assign w_in     = {ctrl_i, data_i, rd_i};
    assign ready_o  = !rst && (r_state != S_FULL);
    assign valid_o  = (r_state != S_EMPTY);
    assign w_accept = valid_i && ready_o;
    assign w_emit   = valid_o && ready_i;

    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt    = S_ONE;
                    w_load_main_in = 1'b1;
                end
            end
            S_ONE: begin
                if (w_accept && w_emit) begin
                    w_load_main_in = 1'b1;
                end else if (w_accept) begin
                    w_state_nxt = S_FULL;
                    w_load_skid = 1'b1;
                end else if (w_emit) begin
                    w_state_nxt = S_EMPTY;
                end
            end
            S_FULL: begin
                if (w_emit) begin
                    w_state_nxt      = S_ONE;
                    w_load_main_skid = 1'b1;
                end
            end
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            r_state <= S_EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load_main_in) begin
                r_main <= w_in;
            end else if (w_load_main_skid) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= w_in;
            end
        end
    end

    // Counter ignores flush; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bubble_cnt <= '0;
        end else if (!valid_o && (r_bubble_cnt != CNT_MAX)) begin
            r_bubble_cnt <= r_bubble_cnt + 1'b1;
        end
    end

    // Bubbles must never present stale control bits downstream.
    assign w_out = valid_o ? r_main : '0;
    assign {ctrl_o, data_o, rd_o} = w_out;
    assign bubble_cnt_o = r_bubble_cnt;

endmodule
